// File: rtl/pc_sequencer_if.sv
// Fetch-front bundle: redirect requests and BTB training in, fetch PC and prediction out.
// master drives requests (pipeline control side), slave is the sequencer.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            pc_stall;
    logic            trapped;
    logic [XLEN-1:0] trap_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_mispredict;
    logic [XLEN-1:0] upd_actual_next;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output pc_stall, trapped, trap_target, jump, jump_target,
               upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_actual_next,
        input  pc, pred_taken, pred_target
    );

    modport slave (
        input  pc_stall, trapped, trap_target, jump, jump_target,
               upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, upd_actual_next,
        output pc, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) and prioritised redirects.
// Latency: redirects and BTB writes take effect after one edge; prediction is combinational on pc.
// Backpressure: pc_stall holds sequential/jump/predicted flow; trap and mispredict override it.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0]        pc_q;
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]  pc_idx;
    logic [IDX-1:0]  upd_idx;
    logic [TAGW-1:0] pc_tag;
    logic [TAGW-1:0] upd_tag;
    logic            lookup_hit;
    logic            upd_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] next_pc;
    logic            unused_upd_lsb;

    assign pc_idx  = pc_q[IDX+1:2];
    assign pc_tag  = pc_q[XLEN-1:IDX+2];
    assign upd_idx = bus.upd_pc[IDX+1:2];
    assign upd_tag = bus.upd_pc[XLEN-1:IDX+2];
    assign unused_upd_lsb = ^bus.upd_pc[1:0];

    assign lookup_hit  = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
    assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign pred_taken  = lookup_hit && btb_ctr[pc_idx][1];
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pred_target = pred_taken ? btb_target[pc_idx] : pc_plus4;

    // Mispredict belongs to an older instruction than the ID jump, so it outranks it and the stall.
    always_comb begin
        next_pc = pred_target;
        if (bus.trapped) begin
            next_pc = bus.trap_target;
        end else if (bus.upd_valid && bus.upd_mispredict) begin
            next_pc = bus.upd_actual_next;
        end else if (bus.pc_stall) begin
            next_pc = pc_q;
        end else if (bus.jump) begin
            next_pc = bus.jump_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else begin
            pc_q <= next_pc;
            // Training is independent of stall and redirect priority.
            if (bus.upd_valid) begin
                if (upd_hit) begin
                    if (bus.upd_taken) begin
                        if (btb_ctr[upd_idx] != 2'b11) begin
                            btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                        end
                        btb_target[upd_idx] <= bus.upd_target;
                    end else if (btb_ctr[upd_idx] != 2'b00) begin
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                    end
                end else if (bus.upd_taken) begin
                    btb_valid[upd_idx]  <= 1'b1;
                    btb_tag[upd_idx]    <= upd_tag;
                    btb_target[upd_idx] <= bus.upd_target;
                    btb_ctr[upd_idx]    <= 2'b10;
                end
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomised checks of pc_sequencer against a table-level BTB/next-PC model.
module tb_pc_sequencer;
    localparam int          N   = 16;
    localparam int          IDX = $clog2(N);
    localparam logic [31:0] RV  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one record per BTB slot, counters as plain integers 0..3.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_pc;

    function automatic int ix(logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic [31:0] tg(logic [31:0] a);
        return a >> (IDX + 2);
    endfunction

    function automatic bit m_pred(logic [31:0] a);
        int e = ix(a);
        return m_valid[e] && (m_tag[e] == tg(a)) && (m_ctr[e] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(logic [31:0] a);
        return m_pred(a) ? m_tgt[ix(a)] : a + 32'd4;
    endfunction

    task automatic m_reset();
        m_pc = RV;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic m_train(logic [31:0] a, bit taken, logic [31:0] t);
        int e = ix(a);
        bit hit = m_valid[e] && (m_tag[e] == tg(a));
        if (hit && taken) begin
            m_ctr[e] = (m_ctr[e] == 3) ? 3 : m_ctr[e] + 1;
            m_tgt[e] = t;
        end else if (hit) begin
            m_ctr[e] = (m_ctr[e] == 0) ? 0 : m_ctr[e] - 1;
        end else if (taken) begin
            m_valid[e] = 1'b1;
            m_tag[e]   = tg(a);
            m_tgt[e]   = t;
            m_ctr[e]   = 2;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.pc_stall        = 1'b0;
        bus.trapped         = 1'b0;
        bus.trap_target     = '0;
        bus.jump            = 1'b0;
        bus.jump_target     = '0;
        bus.upd_valid       = 1'b0;
        bus.upd_pc          = '0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = '0;
        bus.upd_mispredict  = 1'b0;
        bus.upd_actual_next = '0;
    endtask

    // One clock: predict next pc from the model, train, then compare all outputs.
    task automatic step(string tag);
        logic [31:0] nx;
        if (bus.trapped)                            nx = bus.trap_target;
        else if (bus.upd_valid && bus.upd_mispredict) nx = bus.upd_actual_next;
        else if (bus.pc_stall)                      nx = m_pc;
        else if (bus.jump)                          nx = bus.jump_target;
        else                                        nx = m_ptgt(m_pc);
        if (bus.upd_valid) m_train(bus.upd_pc, bus.upd_taken, bus.upd_target);
        @(posedge clk);
        #1;
        m_pc = nx;
        chk({tag, ".pc"}, bus.pc, m_pc);
        chk({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(m_pred(m_pc)));
        chk({tag, ".pred_target"}, bus.pred_target, m_ptgt(m_pc));
    endtask

    task automatic jump_to(string tag, logic [31:0] a);
        bus.jump = 1'b1;
        bus.jump_target = a;
        step(tag);
        clr();
    endtask

    task automatic train(string tag, logic [31:0] a, bit taken, logic [31:0] t);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = a;
        bus.upd_taken  = taken;
        bus.upd_target = t;
        step(tag);
        clr();
    endtask

    initial begin
        clr();
        m_reset();
        reset = 1'b1;
        #3;
        chk("reset.pc", bus.pc, RV);
        chk("reset.pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("reset.pred_target", bus.pred_target, RV + 32'd4);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("seq0");
        chk("seq0.const", bus.pc, 32'h4);

        // Mid-cycle reset from pc=0x100
        jump_to("to100", 32'h100);
        chk("to100.const", bus.pc, 32'h100);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        chk("midrst.pc", bus.pc, 32'h0);
        chk("midrst.pred_taken", 32'(bus.pred_taken), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("rel1");
        chk("rel1.const", bus.pc, 32'h4);
        step("rel2");
        chk("rel2.const", bus.pc, 32'h8);

        // Allocate at 0x40 and predict through it
        train("alloc40", 32'h40, 1'b1, 32'h200);
        jump_to("fetch40", 32'h40);
        chk("fetch40.pt", 32'(bus.pred_taken), 32'd1);
        chk("fetch40.ptgt", bus.pred_target, 32'h200);
        step("follow40");
        chk("follow40.const", bus.pc, 32'h200);

        // Two not-taken updates: 10 -> 01 -> 00
        train("nt1", 32'h40, 1'b0, 32'h0);
        train("nt2", 32'h40, 1'b0, 32'h0);
        jump_to("fetch40b", 32'h40);
        chk("fetch40b.pt", 32'(bus.pred_taken), 32'd0);
        chk("fetch40b.ptgt", bus.pred_target, 32'h44);

        // Aliasing: retrain 0x40 up to weakly taken, then fetch/evict via 0x80
        train("re40a", 32'h40, 1'b1, 32'h200);
        train("re40b", 32'h40, 1'b1, 32'h200);
        jump_to("fetch80", 32'h80);
        chk("alias.pt", 32'(bus.pred_taken), 32'd0);
        train("alloc80", 32'h80, 1'b1, 32'h600);
        jump_to("fetch40c", 32'h40);
        chk("evict.pt", 32'(bus.pred_taken), 32'd0);
        jump_to("fetch80b", 32'h80);
        chk("hit80.ptgt", bus.pred_target, 32'h600);

        // Priority
        bus.trapped = 1'b1;        bus.trap_target     = 32'h8000_0000;
        bus.jump = 1'b1;           bus.jump_target     = 32'h500;
        bus.upd_valid = 1'b1;      bus.upd_mispredict  = 1'b1;
        bus.upd_actual_next = 32'h300; bus.upd_pc = 32'h10;
        step("prio_trap");
        clr();
        chk("prio_trap.const", bus.pc, 32'h8000_0000);
        bus.jump = 1'b1;           bus.jump_target     = 32'h500;
        bus.upd_valid = 1'b1;      bus.upd_mispredict  = 1'b1;
        bus.upd_actual_next = 32'h300; bus.upd_pc = 32'h10;
        step("prio_mis");
        clr();
        chk("prio_mis.const", bus.pc, 32'h300);

        // Stall
        bus.pc_stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h500;
        step("stall_jump");
        clr();
        chk("stall_jump.const", bus.pc, 32'h300);
        bus.pc_stall = 1'b1; bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b1;
        bus.upd_actual_next = 32'h44; bus.upd_pc = 32'h2C;
        step("stall_mis");
        clr();
        chk("stall_mis.const", bus.pc, 32'h44);

        // Wrap
        jump_to("towrap", 32'hFFFF_FFFC);
        step("wrap");
        chk("wrap.const", bus.pc, 32'h0);

        // Randomised traffic over a small address window to provoke hits and aliasing
        for (int k = 0; k < 3000; k++) begin
            bus.pc_stall        = ($urandom_range(0, 4) == 0);
            bus.trapped         = ($urandom_range(0, 30) == 0);
            bus.trap_target     = 32'($urandom_range(0, 255)) << 2;
            bus.jump            = ($urandom_range(0, 9) == 0);
            bus.jump_target     = 32'($urandom_range(0, 255)) << 2;
            bus.upd_valid       = ($urandom_range(0, 2) != 0);
            bus.upd_pc          = 32'($urandom_range(0, 255)) << 2;
            bus.upd_taken       = ($urandom_range(0, 2) != 0);
            bus.upd_target      = (32'($urandom_range(0, 255)) << 2)
                                  | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            bus.upd_mispredict  = ($urandom_range(0, 7) == 0);
            bus.upd_actual_next = 32'($urandom_range(0, 255)) << 2;
            step("rand");
        end
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the combinational next-PC selector. It owns the architectural fetch PC register and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so the predicted taken flag and target are produced internally rather than supplied by the fetch stage. It sits at the front of the fetch stage. Redirects come from the trap controller, the ID-stage jump resolver, and the EX-stage branch resolver, which also trains the BTB.

## Interface
- XLEN, 32, address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Width is XLEN.
- BTB_ENTRIES, 16, number of BTB entries. Must be a power of two, ≥2. IDX = log2(BTB_ENTRIES).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_stall  in  1  hold PC (hazard stall).
- trapped  in  1  trap/exception/return redirect request.
- trap_target  in  XLEN  trap redirect address.
- jump  in  1  ID-stage JAL/JALR redirect.
- jump_target  in  XLEN  jump address.
- upd_valid  in  1  EX stage resolved a conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  XLEN  actual taken target.
- upd_mispredict  in  1  EX detected a misprediction. Only meaningful with upd_valid.
- upd_actual_next  in  XLEN  correct next PC after the mispredicted branch.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  BTB predicts that the instruction at pc is a taken branch.
- pred_target  out  XLEN  predicted target. Equals pc+4 when pred_taken=0.

## Operation
- **Index and tag fields:**
  - Index = addr[IDX+1:2].
  - Tag = addr[XLEN-1:IDX+2].
  - Each entry holds: valid, tag, target (XLEN), ctr (2 bits).
- **Lookup (combinational on pc):**
  - hit = valid[idx] && tag[idx]==pc tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc+4.
- **Next-PC priority, highest first:**
  1. trapped → trap_target.
  2. upd_valid && upd_mispredict → upd_actual_next. The older EX instruction wins over a younger ID jump.
  3. jump → jump_target.
  4. pred_taken → pred_target.
  5. Otherwise → pc+4.
- **Stall:**
  - pc_stall holds pc for sources 3–5.
  - Trap and mispredict redirects override pc_stall and load in the same cycle.
- **Training** (on upd_valid, independent of pc_stall and of redirect priority), at entry e = index(upd_pc):
  - Hit, taken: ctr saturating increment (max 2'b11); target ← upd_target.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate. valid←1, tag←tag(upd_pc), target←upd_target, ctr←2'b10. Replaces any previous occupant.
  - Miss, not taken: no change.
- **Arithmetic:**
  - pc+4 wraps modulo 2^XLEN (all-ones-minus-3 → 0).
  - Target bits [1:0] pass through unmodified; alignment faults are the trap unit's concern.

## Timing
- **Reset (asynchronous assert, immediate):**
  - pc = RESET_VECTOR.
  - All valid = 0; all ctr = 2'b01.
  - Hence pred_taken = 0 and pred_target = RESET_VECTOR+4.
  - Reset asserted mid-operation discards all state in the same instant.
  - First update is on the first rising edge after deassertion.
- **Redirect latency:** a redirect presented in cycle N appears on pc after the edge ending cycle N (1 cycle). Prediction outputs are valid in the same cycle as pc.
- **Training latency:** a BTB write at edge N is visible to lookup from cycle N+1. If lookup and update target the same index in the same cycle, lookup sees the old contents.
- **Simultaneous events:**
  - trapped together with any other request → trap only. Training still occurs if upd_valid.
  - Mispredict together with jump → upd_actual_next.
  - Mispredict while pc_stall=1 → load upd_actual_next.
  - jump while pc_stall=1 → hold. The ID stage re-presents the jump.

## Test plan
- **Reset:** assert reset mid-cycle with pc=0x100 → pc=0x0 immediately, pred_taken=0. After release, pc goes 0x4, 0x8, and so on.
- **Allocate and predict:**
  - Stimulus: upd_valid=1, upd_pc=0x40, upd_taken=1, upd_target=0x200.
  - Next time pc=0x40 → pred_taken=1, pred_target=0x200, and the following pc=0x200.
  - Two not-taken updates at 0x40 move ctr 10→01→00, after which pred_taken=0.
- **Aliasing (BTB_ENTRIES=16):** entry trained at 0x40; fetch pc=0x80 (same index, different tag) → pred_taken=0. A taken update at 0x80 evicts the 0x40 entry.
- **Priority:**
  - trapped=1 with trap_target=0x8000_0000, together with jump=1 and a mispredict → pc=0x8000_0000.
  - Without trapped: mispredict (upd_actual_next=0x300) together with jump (0x500) → pc=0x300.
- **Stall:**
  - pc_stall=1 with jump=1 → pc held.
  - pc_stall=1 with upd_mispredict=1 and upd_actual_next=0x44 → pc=0x44 next cycle.
- **Wrap:** with XLEN=32 and pc=0xFFFF_FFFC, no redirect → next pc=0x0000_0000.
